// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scanner:
// FSM encoding, active-low segment patterns and anode helpers.
package display_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  function automatic logic [3:0] anode_for_slot(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes A-F render
// as a dark digit.
module seg7_decode
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with anti-ghost blanking, per-digit
// blink, decimal points and leading-zero suppression of the leftmost digit.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  slot,
  output logic        frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  scan_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    slot_reg;
  logic [3:0]    code_reg;
  logic          blink_bit_reg;
  logic          dp_bit_reg;
  logic          blink_phase_reg;
  logic [FW-1:0] frame_cnt_reg;

  logic [3:0] slot_code [4];
  logic [6:0] dec_seg;
  logic       cnt_last;
  logic       frame_end;
  logic       suppress;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot_code
      assign slot_code[gi] = digits[gi*4 +: 4];
    end
  endgenerate

  seg7_decode u_seg7_decode (
    .code (code_reg),
    .seg  (dec_seg)
  );

  assign cnt_last  = (cnt_reg == CW'(PRESCALE - 1));
  assign frame_end = cnt_last && (slot_reg == 2'd3);
  assign suppress  = (blink_phase_reg && blink_bit_reg) ||
                     (lz_blank && (slot_reg == 2'd3) && (code_reg == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_BLANK;
      cnt_reg         <= '0;
      slot_reg        <= 2'd0;
      code_reg        <= 4'd0;
      blink_bit_reg   <= 1'b0;
      dp_bit_reg      <= 1'b0;
      blink_phase_reg <= 1'b0;
      frame_cnt_reg   <= '0;
      anode           <= ANODE_OFF;
      seg             <= SEG_BLANK;
      dp              <= 1'b1;
      slot            <= 2'd0;
      frame_done      <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt_reg   <= '0;
        slot_reg  <= slot_reg + 2'd1;
        state_reg <= ST_BLANK;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
        if (cnt_reg == CW'(BLANK_CYCLES - 1))
          state_reg <= ST_DRIVE;
      end

      // Snapshot the new slot's inputs on its first cycle so that
      // mid-slot input changes cannot tear the displayed digit.
      if (cnt_reg == '0) begin
        code_reg      <= slot_code[slot_reg];
        blink_bit_reg <= blink_mask[slot_reg];
        dp_bit_reg    <= dp_mask[slot_reg];
      end

      if (frame_end) begin
        if (frame_cnt_reg == FW'(BLINK_DIV - 1)) begin
          frame_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FW'(1);
        end
      end

      slot       <= slot_reg;
      frame_done <= frame_end;

      // The blank window at each slot start keeps old and new anodes
      // from ever overlapping during the handover.
      if (state_reg == ST_BLANK || suppress) begin
        anode <= ANODE_OFF;
        seg   <= SEG_BLANK;
        dp    <= 1'b1;
      end else begin
        anode <= anode_for_slot(slot_reg);
        seg   <= dec_seg;
        dp    <= ~dp_bit_reg;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl with a closed-form
// timing model and a few hand-computed anchor points.
module tb_display_scan_ctrl;

  localparam int P    = 8;
  localparam int BC   = 2;
  localparam int BD   = 2;
  localparam int MAXN = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic        lz_blank = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  slot;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  logic [15:0] h_dig [MAXN];
  logic [3:0]  h_blk [MAXN];
  logic [3:0]  h_dp  [MAXN];
  logic        h_lz  [MAXN];

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .slot       (slot),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // n = number of clock edges since reset release = DUT time step index
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0;
    end else begin
      if (n < MAXN) begin
        h_dig[n] <= digits;
        h_blk[n] <= blink_mask;
        h_dp[n]  <= dp_mask;
        h_lz[n]  <= lz_blank;
      end
      n <= n + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, n, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected outputs after the edge that closes time step s
  function automatic void model(input int s, output logic [3:0] an, output logic [6:0] sg,
                                output logic d, output logic [1:0] sl, output logic fd,
                                output logic supp);
    int c, sn, ss, phase;
    logic [15:0] dg;
    logic [3:0] code;
    c     = s % P;
    sn    = (s / P) % 4;
    ss    = s - c;
    phase = ((s / (4 * P)) / BD) % 2;
    dg    = h_dig[ss];
    code  = dg[sn*4 +: 4];
    sl    = 2'(sn);
    fd    = (c == P - 1) && (sn == 3);
    supp  = 1'b0;
    if (c < BC) begin
      an = 4'hF; sg = 7'h7F; d = 1'b1;
    end else begin
      supp = ((phase == 1) && h_blk[ss][sn]) || (h_lz[s] && sn == 3 && code == 4'd0);
      an   = supp ? 4'hF : ~(4'b0001 << sn);
      sg   = seg_of(code);
      d    = supp ? 1'b1 : ~h_dp[ss][sn];
    end
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_sg;
    logic e_d, e_fd, e_supp;
    logic [1:0] e_sl;
    if (rst || n == 0) begin
      chk("rst_anode", 16'(anode), 16'hF);
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_dp", 16'(dp), 16'd1);
      chk("rst_slot", 16'(slot), 16'd0);
      chk("rst_frame_done", 16'(frame_done), 16'd0);
    end else if (n - 1 < MAXN) begin
      model(n - 1, e_an, e_sg, e_d, e_sl, e_fd, e_supp);
      chk("anode", 16'(anode), 16'(e_an));
      if (!e_supp) chk("seg", 16'(seg), 16'(e_sg));
      chk("dp", 16'(dp), 16'(e_d));
      chk("slot", 16'(slot), 16'(e_sl));
      chk("frame_done", 16'(frame_done), 16'(e_fd));
    end
    chk("one_anode_low", 16'($countones(~anode) <= 1), 16'd1);
  end

  task automatic wait_n(input int m);
    int guard = 0;
    while (n != m && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (n != m) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_step actual=%0d required=%0d", n, m);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_anode", 16'(anode), 16'hF);
    chk("async_rst_slot", 16'(slot), 16'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    // Reset release and first two slots with 1234
    digits = 16'h1234; blink_mask = 4'b0000; dp_mask = 4'b0000; lz_blank = 1'b0;
    do_reset();
    wait_n(1);  chk("first_blank", 16'(anode), 16'hF);
    wait_n(3);  chk("s0_anode", 16'(anode), 16'hE); chk("s0_seg4", 16'(seg), 16'h19);
    wait_n(9);  chk("gap_anode", 16'(anode), 16'hF);
    wait_n(11); chk("s1_anode", 16'(anode), 16'hD); chk("s1_seg3", 16'(seg), 16'h30);
    wait_n(19); chk("s2_anode", 16'(anode), 16'hB); chk("s2_seg2", 16'(seg), 16'h24);
    wait_n(27); chk("s3_anode", 16'(anode), 16'h7); chk("s3_seg1", 16'(seg), 16'h79);
    wait_n(31); chk("fd_before", 16'(frame_done), 16'd0);
    wait_n(32); chk("fd_pulse", 16'(frame_done), 16'd1);
    wait_n(33); chk("fd_after", 16'(frame_done), 16'd0);

    // Mid-slot digit change takes effect from the next slot
    do_reset();
    wait_n(5); digits = 16'h5678;
    wait_n(6);  chk("hold_seg", 16'(seg), 16'h19);
    wait_n(8);  chk("hold_seg_end", 16'(seg), 16'h19);
    wait_n(11); chk("new_s1_anode", 16'(anode), 16'hD); chk("new_s1_seg7", 16'(seg), 16'h78);

    // Blink on slot 0, then reset during slot 2 DRIVE while blink phase is 1
    digits = 16'h1234; blink_mask = 4'b0001;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      wait_n(3 + 32 * f);
      chk("blink_s0", 16'(anode), (f == 2 || f == 3) ? 16'hF : 16'hE);
      if (f == 2) begin
        wait_n(75); chk("blink_s1_driven", 16'(anode), 16'hD);
      end
    end
    do_reset();
    wait_n(3 + 64 + 16 + 1);
    chk("pre_rst_s2", 16'(anode), 16'hB);
    do_reset();
    wait_n(3); chk("post_rst_s0", 16'(anode), 16'hE); chk("post_rst_slot", 16'(slot), 16'd0);
    blink_mask = 4'b0000;

    // Leading-zero blank, hex code, decimal point
    digits = 16'h0A59; lz_blank = 1'b1; dp_mask = 4'b0100;
    do_reset();
    wait_n(3);  chk("lz_s0", 16'(anode), 16'hE); chk("lz_s0_seg9", 16'(seg), 16'h10); chk("lz_s0_dp", 16'(dp), 16'd1);
    wait_n(11); chk("lz_s1", 16'(anode), 16'hD); chk("lz_s1_seg5", 16'(seg), 16'h12); chk("lz_s1_dp", 16'(dp), 16'd1);
    wait_n(19); chk("lz_s2", 16'(anode), 16'hB); chk("lz_s2_segA", 16'(seg), 16'h7F); chk("lz_s2_dp", 16'(dp), 16'd0);
    wait_n(27); chk("lz_s3_blank", 16'(anode), 16'hF); chk("lz_s3_dp", 16'(dp), 16'd1);
    wait_n(40); lz_blank = 1'b0;
    wait_n(59); chk("nolz_s3", 16'(anode), 16'h7); chk("nolz_s3_seg0", 16'(seg), 16'h40);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(19, 0) == 0) digits = 16'($urandom);
      if ($urandom_range(39, 0) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(39, 0) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(49, 0) == 0) lz_blank = 1'($urandom);
      if (i == 1500) do_reset();
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
